// File: rtl/digit_scan_display.sv
// ============================================================================
// digit_scan_display : 4-digit multiplexed 7-segment scanner fed by UART digits
// Optional macro DIGIT_LEADING_BLANK_EN blanks never-filled positions.
// Revision: 1.0
// ============================================================================
`default_nettype none

module digit_scan_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int FRESH_TICKS = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp,
  output logic [15:0] hist
);

  localparam int              CNT_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [15:0]     FRESH_LOAD = 16'(FRESH_TICKS);

  logic [CNT_W-1:0] slot_cnt;
  logic [1:0]       idx;
  logic [1:0]       next_idx;
  logic [15:0]      fresh;
  logic             tick;
  logic             accept;
  logic             clear_req;
  logic [3:0]       sel_digit;
  logic [6:0]       sel_code;

  assign tick      = (slot_cnt == CNT_MAX);
  assign accept    = in_valid && (in_byte >= 8'h30) && (in_byte <= 8'h39);
  assign clear_req = in_valid && ((in_byte == 8'h43) || (in_byte == 8'h63));
  assign next_idx  = idx + 2'd1;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'h40;
      4'd1:    c = 7'h79;
      4'd2:    c = 7'h24;
      4'd3:    c = 7'h30;
      4'd4:    c = 7'h19;
      4'd5:    c = 7'h12;
      4'd6:    c = 7'h02;
      4'd7:    c = 7'h78;
      4'd8:    c = 7'h00;
      4'd9:    c = 7'h10;
      default: c = 7'h7F;
    endcase
    return c;
  endfunction

  always_comb begin
    sel_digit = hist[3:0];
    case (next_idx)
      2'd0: sel_digit = hist[3:0];
      2'd1: sel_digit = hist[7:4];
      2'd2: sel_digit = hist[11:8];
      2'd3: sel_digit = hist[15:12];
      default: sel_digit = hist[3:0];
    endcase
  end

`ifdef DIGIT_LEADING_BLANK_EN
  logic [3:0] mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      mask <= 4'b0000;
    end else if (clear_req) begin
      mask <= 4'b0000;
    end else if (accept) begin
      mask <= {mask[2:0], 1'b1};
    end
  end

  assign sel_code = mask[next_idx] ? seg_code(sel_digit) : 7'h7F;
`else
  assign sel_code = seg_code(sel_digit);
`endif

  // Display registers sample the pre-update history, so a digit accepted on
  // a tick edge only shows up from the following slot onwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt <= '0;
      idx      <= 2'd0;
      an       <= 4'b1110;
      seg      <= 7'h7F;
      dp       <= 1'b1;
      hist     <= 16'h0000;
      fresh    <= 16'h0000;
    end else begin
      slot_cnt <= tick ? '0 : slot_cnt + 1'b1;

      if (tick) begin
        idx <= next_idx;
        an  <= ~(4'b0001 << next_idx);
        seg <= sel_code;
        dp  <= !((next_idx == 2'd0) && (fresh != 16'h0000));
      end

      if (clear_req) begin
        hist  <= 16'h0000;
        fresh <= 16'h0000;
      end else if (accept) begin
        hist  <= {hist[11:0], in_byte[3:0]};
        fresh <= FRESH_LOAD;
      end else if (tick && (fresh != 16'h0000)) begin
        fresh <= fresh - 16'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_digit_scan_display.sv
// ============================================================================
// tb_digit_scan_display : table-driven and sequence checks for digit_scan_display
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_digit_scan_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic [15:0] hist;

  int checks = 0;
  int errors = 0;

`ifdef DIGIT_LEADING_BLANK_EN
  localparam logic [6:0] BLANK_EXP = 7'h7F;
`else
  localparam logic [6:0] BLANK_EXP = 7'h40;
`endif

  digit_scan_display #(
    .REFRESH_DIV(4),
    .FRESH_TICKS(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_byte(in_byte),
    .in_valid(in_valid),
    .seg(seg),
    .an(an),
    .dp(dp),
    .hist(hist)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [7:0]  b;
    logic [15:0] exp_hist;
    logic        chk;
    logic [6:0]  seg0;
  } vec_t;

  vec_t        vecs[13];
  logic [15:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the first negedge of a new slot on target.
  task automatic wait_entry(input logic [3:0] target);
    int n;
    n = 0;
    while (an == target && n < 64) begin
      @(negedge clk);
      n++;
    end
    while (an != target && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("wait_entry_an", {28'd0, an}, {28'd0, target});
  endtask

  task automatic do_reset_check();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_byte  = 8'h38;
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_an",   {28'd0, an},   32'h0000000E);
    check("rst_seg",  {25'd0, seg},  32'h0000007F);
    check("rst_dp",   {31'd0, dp},   32'h00000001);
    check("rst_hist", {16'd0, hist}, 32'h00000000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("tick_early_an", {28'd0, an}, 32'h0000000E);
    @(posedge clk);
    @(negedge clk);
    check("first_tick_an",  {28'd0, an},  32'h0000000D);
    check("first_tick_seg", {25'd0, seg}, {25'd0, BLANK_EXP});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [15:0] exp;

    vecs[0]  = '{1'b1, 8'h31, 16'h0001, 1'b0, 7'h00};
    vecs[1]  = '{1'b1, 8'h32, 16'h0012, 1'b0, 7'h00};
    vecs[2]  = '{1'b1, 8'h33, 16'h0123, 1'b0, 7'h00};
    vecs[3]  = '{1'b1, 8'h34, 16'h1234, 1'b0, 7'h00};
    vecs[4]  = '{1'b1, 8'h35, 16'h2345, 1'b1, 7'h12};
    vecs[5]  = '{1'b1, 8'h41, 16'h2345, 1'b0, 7'h00};
    vecs[6]  = '{1'b1, 8'h3A, 16'h2345, 1'b0, 7'h00};
    vecs[7]  = '{1'b1, 8'h2F, 16'h2345, 1'b0, 7'h00};
    vecs[8]  = '{1'b1, 8'h63, 16'h0000, 1'b1, BLANK_EXP};
    vecs[9]  = '{1'b1, 8'h39, 16'h0009, 1'b0, 7'h00};
    vecs[10] = '{1'b1, 8'h43, 16'h0000, 1'b0, 7'h00};
    vecs[11] = '{1'b1, 8'h37, 16'h0007, 1'b1, 7'h78};
    vecs[12] = '{1'b0, 8'h38, 16'h0007, 1'b0, 7'h00};

    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset_check();

    for (int i = 0; i < 13; i++) begin
      in_valid = vecs[i].vld;
      in_byte  = vecs[i].b;
      sb.push_back(vecs[i].exp_hist);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      exp = sb.pop_front();
      check($sformatf("hist_vec%0d", i), {16'd0, hist}, {16'd0, exp});
      if (vecs[i].chk) begin
        wait_entry(4'b1110);
        check($sformatf("seg_d0_vec%0d", i), {25'd0, seg}, {25'd0, vecs[i].seg0});
      end
    end

    // Positions 1..3 after a single '7' following a clear
    wait_entry(4'b1101);
    check("blank_d1", {25'd0, seg}, {25'd0, BLANK_EXP});
    wait_entry(4'b1011);
    check("blank_d2", {25'd0, seg}, {25'd0, BLANK_EXP});
    wait_entry(4'b0111);
    check("blank_d3", {25'd0, seg}, {25'd0, BLANK_EXP});

    // Collision: '9' accepted on the tick that enters index 0
    wait_entry(4'b0111);
    repeat (3) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = 8'h39;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("coll_an",   {28'd0, an},   32'h0000000E);
    check("coll_seg",  {25'd0, seg},  32'h00000078);
    check("coll_dp",   {31'd0, dp},   32'h00000001);
    check("coll_hist", {16'd0, hist}, 32'h00000079);
    wait_entry(4'b1101);
    check("coll_d1_seg", {25'd0, seg}, 32'h00000078);
    wait_entry(4'b1110);
    check("coll_next_seg", {25'd0, seg}, 32'h00000010);
    check("coll_next_dp",  {31'd0, dp},  32'h00000001);

    // Decimal point: '3' accepted on the tick entering index 2
    wait_entry(4'b1101);
    repeat (3) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = 8'h33;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("dp_an_slot2",  {28'd0, an},   32'h0000000B);
    check("dp_slot2",     {31'd0, dp},   32'h00000001);
    check("dp_seg_slot2", {25'd0, seg},  {25'd0, BLANK_EXP});
    check("dp_hist",      {16'd0, hist}, 32'h00000793);
    wait_entry(4'b0111);
    check("dp_slot3", {31'd0, dp}, 32'h00000001);
    wait_entry(4'b1110);
    check("dp_slot0_lit", {31'd0, dp},  32'h00000000);
    check("dp_slot0_seg", {25'd0, seg}, 32'h00000030);
    wait_entry(4'b1101);
    check("dp_slot1", {31'd0, dp},  32'h00000001);
    check("dp_seg1",  {25'd0, seg}, 32'h00000010);
    wait_entry(4'b1110);
    check("dp_expired", {31'd0, dp}, 32'h00000001);

    // Reset in the middle of a slot, with a digit strobe on the same edge
    wait_entry(4'b1011);
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
